// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: port 0 (MEM stage) has
// fixed priority, port 1 (loader/debug) is forced through after a run of denied cycles.
module dmem_arbiter #(
  parameter int unsigned DEPTH        = 101,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);
  localparam logic [3:0]  LIMIT   = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;
  logic       force_p1;
  logic       p0_inr;
  logic       p1_inr;

  function automatic logic [3:0] sat_inc(input logic [3:0] cnt, input logic [3:0] lim);
    return (cnt < lim) ? 4'(cnt + 4'd1) : lim;
  endfunction

  assign p0_inr = (p0_addr < DEPTH_W);
  assign p1_inr = (p1_addr < DEPTH_W);

  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (!rst) begin
      if (force_p1) begin
        p1_gnt = p1_req;
        p0_gnt = p0_req & ~p1_req;
      end else begin
        p0_gnt = p0_req;
        p1_gnt = p1_req & ~p0_req;
      end
    end
  end

  // Out-of-range accesses are granted but never strobe the memory.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (p0_gnt) begin
      mem_addr  = p0_addr;
      mem_wdata = p0_wdata;
      mem_read  = ~p0_we & p0_inr;
      mem_write = p0_we & p0_inr;
    end else if (p1_gnt) begin
      mem_addr  = p1_addr;
      mem_wdata = p1_wdata;
      mem_read  = ~p1_we & p1_inr;
      mem_write = p1_we & p1_inr;
    end
  end

  // Response stage: one cycle after the grant; rdata of an idle port holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      p0_rvalid <= 1'b0;
      p0_err    <= 1'b0;
      p0_rdata  <= '0;
      p1_rvalid <= 1'b0;
      p1_err    <= 1'b0;
      p1_rdata  <= '0;
    end else begin
      p0_rvalid <= p0_gnt;
      p0_err    <= p0_gnt & ~p0_inr;
      if (p0_gnt) p0_rdata <= (~p0_we & p0_inr) ? mem_rdata : '0;
      p1_rvalid <= p1_gnt;
      p1_err    <= p1_gnt & ~p1_inr;
      if (p1_gnt) p1_rdata <= (~p1_we & p1_inr) ? mem_rdata : '0;
    end
  end

  // force_p1 rises the cycle after the counter saturates and drops after p1 is served
  // (or abandons its request while forced).
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      force_p1   <= 1'b0;
    end else begin
      if (p1_gnt)
        starve_cnt <= '0;
      else if (p1_req)
        starve_cnt <= sat_inc(starve_cnt, LIMIT);
      else if (force_p1)
        starve_cnt <= '0;
      force_p1 <= (starve_cnt == LIMIT) & ~p1_gnt & ~(force_p1 & ~p1_req);
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter: a transaction-level model tracks grants, the
// denied-request streak of port 1 and a shadow copy of memory.
module tb_dmem_arbiter;
  localparam int DEPTH        = 101;
  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_we, p0_gnt, p0_rvalid, p0_err;
  logic [31:0] p0_addr, p0_wdata, p0_rdata;
  logic        p1_req, p1_we, p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p1_addr, p1_wdata, p1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;

  dmem_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory attached to the arbiter: combinational read, write on negedge.
  logic [31:0] tb_mem [DEPTH];
  always @(negedge clk) if (mem_write && mem_addr < DEPTH) tb_mem[mem_addr] <= mem_wdata;
  assign mem_rdata = (mem_addr < DEPTH) ? tb_mem[mem_addr] : 32'hBAD0_BAD0;

  // Reference model state
  logic [31:0] ref_mem [DEPTH];
  int          streak;
  bit          forced;
  bit          r_req [2];
  bit          r_we  [2];
  logic [31:0] r_addr  [2];
  logic [31:0] r_wdata [2];
  bit          exp_rvalid [2];
  bit          exp_err    [2];
  logic [31:0] exp_rdata  [2];
  bit          obs_g0, obs_g1;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 9))
      0:       return 32'(DEPTH);
      1:       return 32'(DEPTH - 1);
      2:       return $urandom | 32'h8000_0000;
      3:       return 32'd0;
      default: return 32'($urandom_range(0, DEPTH - 1));
    endcase
  endfunction

  task automatic new_req(input int p);
    r_req[p]   = ($urandom_range(0, 99) < ((p == 0) ? 70 : 45));
    r_we[p]    = 1'($urandom_range(0, 1));
    r_addr[p]  = pick_addr();
    r_wdata[p] = $urandom;
  endtask

  task automatic drive();
    p0_req = r_req[0]; p0_we = r_we[0]; p0_addr = r_addr[0]; p0_wdata = r_wdata[0];
    p1_req = r_req[1]; p1_we = r_we[1]; p1_addr = r_addr[1]; p1_wdata = r_wdata[1];
  endtask

  task automatic model_reset();
    streak = 0;
    forced = 1'b0;
    for (int p = 0; p < 2; p++) begin
      exp_rvalid[p] = 1'b0;
      exp_err[p]    = 1'b0;
      exp_rdata[p]  = '0;
    end
  endtask

  // Entered 1 time unit after a posedge; returns 1 time unit after the next posedge.
  task automatic do_reset();
    rst = 1'b1;
    drive();
    #2;
    chk("rst_p0_gnt", p0_gnt, 0);
    chk("rst_p1_gnt", p1_gnt, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    chk("rst_p0_rvalid", p0_rvalid, 0);
    chk("rst_p1_rvalid", p1_rvalid, 0);
    chk("rst_p0_rdata", p0_rdata, 0);
    chk("rst_p1_rdata", p1_rdata, 0);
    chk("rst_p0_err", p0_err, 0);
    chk("rst_p1_err", p1_err, 0);
  endtask

  task automatic step(input bit auto_req);
    bit          g0, g1, any, inr, nxt_forced;
    int          w;
    logic [31:0] ea, ew;
    bit          erd, ewr;
    drive();
    #2;
    g1  = r_req[1] && (forced || !r_req[0]);
    g0  = r_req[0] && !g1;
    any = g0 || g1;
    w   = g1 ? 1 : 0;
    obs_g0 = p0_gnt;
    obs_g1 = p1_gnt;
    chk("p0_gnt", p0_gnt, g0);
    chk("p1_gnt", p1_gnt, g1);
    inr = any && (r_addr[w] < DEPTH);
    ea  = any ? r_addr[w] : 32'd0;
    ew  = any ? r_wdata[w] : 32'd0;
    erd = any && inr && !r_we[w];
    ewr = any && inr && r_we[w];
    chk("mem_addr", mem_addr, ea);
    chk("mem_wdata", mem_wdata, ew);
    chk("mem_read", mem_read, erd);
    chk("mem_write", mem_write, ewr);
    for (int p = 0; p < 2; p++) begin
      exp_rvalid[p] = any && (p == w);
      if (exp_rvalid[p]) begin
        exp_err[p]   = !inr;
        exp_rdata[p] = erd ? ref_mem[ea] : 32'd0;
      end
    end
    if (ewr) ref_mem[ea] = ew;
    nxt_forced = (streak == STARVE_LIMIT) && !g1 && !(forced && !r_req[1]);
    if (g1) streak = 0;
    else if (r_req[1]) streak = (streak < STARVE_LIMIT) ? streak + 1 : streak;
    else if (forced) streak = 0;
    forced = nxt_forced;
    @(posedge clk); #1;
    chk("p0_rvalid", p0_rvalid, exp_rvalid[0]);
    chk("p1_rvalid", p1_rvalid, exp_rvalid[1]);
    chk("p0_rdata", p0_rdata, exp_rdata[0]);
    chk("p1_rdata", p1_rdata, exp_rdata[1]);
    if (exp_rvalid[0]) chk("p0_err", p0_err, exp_err[0]);
    if (exp_rvalid[1]) chk("p1_err", p1_err, exp_err[1]);
    if (auto_req) begin
      if (g0 || !r_req[0]) new_req(0);
      if (g1 || !r_req[1]) new_req(1);
    end
  endtask

  task automatic set_req(input int p, input bit req, input bit we,
                         input logic [31:0] addr, input logic [31:0] wdata);
    r_req[p] = req; r_we[p] = we; r_addr[p] = addr; r_wdata[p] = wdata;
  endtask

  initial begin
    logic [31:0] v;
    rst = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      v = $urandom;
      tb_mem[i]  = v;
      ref_mem[i] = v;
    end
    tb_mem[2]  = 32'h0000_0005;
    ref_mem[2] = 32'h0000_0005;
    set_req(0, 1, 0, 32'd7, 32'd0);
    set_req(1, 1, 0, 32'd9, 32'd0);
    drive();
    @(posedge clk); #1;
    do_reset();
    step(0);                                   // p0 wins right after reset
    chk("post_rst_p0_first", obs_g0, 1);

    set_req(0, 1, 0, 32'd2, 32'd0);
    set_req(1, 0, 0, 32'd0, 32'd0);
    step(0);
    chk("p0_read_addr2", p0_rdata, 32'h5);
    set_req(0, 0, 0, 32'd0, 32'd0);
    set_req(1, 1, 1, 32'd22, 32'hDEAD_BEEF);
    step(0);
    set_req(1, 1, 0, 32'd22, 32'd0);
    step(0);
    chk("p1_readback22", p1_rdata, 32'hDEAD_BEEF);

    set_req(0, 1, 1, 32'd101, 32'h1234_5678);
    set_req(1, 0, 0, 32'd0, 32'd0);
    step(0);
    chk("oor_err", p0_err, 1);
    chk("oor_rdata", p0_rdata, 0);

    // Both requesting continuously: p1 served every sixth cycle.
    set_req(0, 1, 0, 32'd3, 32'd0);
    set_req(1, 1, 0, 32'd4, 32'd0);
    for (int i = 0; i < 12; i++) begin
      step(0);
      chk("starve_seq", obs_g1, (i % 6) == 5);
    end
    for (int i = 0; i < 3; i++) step(0);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(0);
      chk("post_rst_p0_wins", obs_g0, 1);
    end

    new_req(0);
    new_req(1);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
        new_req(0);
        new_req(1);
      end else begin
        step(1);
      end
    end

    set_req(0, 0, 0, 32'd0, 32'd0);
    set_req(1, 0, 0, 32'd0, 32'd0);
    step(0);
    for (int i = 0; i < DEPTH; i++) chk("mem_contents", tb_mem[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
